// File: rtl/fifo_wr_ctrl_if.sv
// Write-side handshake bundle between the FIFO write port and its pointer/flag controller.
interface fifo_wr_ctrl_if #(
    parameter int unsigned ADDRSIZE = 8
);
    logic                winc;
    logic [ADDRSIZE:0]   rptr_gray;
    logic                woverflow_clr;
    logic [ADDRSIZE-1:0] waddr;
    logic [ADDRSIZE:0]   wptr;
    logic                wfull;
    logic                walmost_full;
    logic [ADDRSIZE:0]   wlevel;
    logic                woverflow;

    // Write-side client: issues requests, observes pointers and flags
    modport master (
        output winc,
        output rptr_gray,
        output woverflow_clr,
        input  waddr,
        input  wptr,
        input  wfull,
        input  walmost_full,
        input  wlevel,
        input  woverflow
    );

    // Controller side
    modport slave (
        input  winc,
        input  rptr_gray,
        input  woverflow_clr,
        output waddr,
        output wptr,
        output wfull,
        output walmost_full,
        output wlevel,
        output woverflow
    );
endinterface

// File: rtl/fifo_wr_ctrl.sv
// Async FIFO write-domain controller: binary/Gray write pointer, read-pointer
// synchronizer, full / almost-full / level flags and a sticky overflow flag.
// ADDRSIZE must be >= 2 so the full comparison has a distinct lower field.
module fifo_wr_ctrl #(
    parameter int unsigned ADDRSIZE     = 8,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned AFULL_THRESH = (2 ** ADDRSIZE) - 4
) (
    input  logic         wclk,
    input  logic         wrst,
    fifo_wr_ctrl_if.slave bus
);
    localparam int unsigned PW = ADDRSIZE + 1;

    logic [PW-1:0] wbin_q;
    logic [PW-1:0] wbin_d;
    logic [PW-1:0] wptr_q;
    logic [PW-1:0] wgray_d;
    logic [PW-1:0] sync_q [SYNC_STAGES];
    logic [PW-1:0] wq_rptr;
    logic [PW-1:0] rbin;
    logic [PW-1:0] fill_d;
    logic [PW-1:0] full_cmp;
    logic          push;
    logic          wfull_q;
    logic          wfull_d;
    logic          wafull_q;
    logic          wafull_d;
    logic [PW-1:0] wlevel_q;
    logic          wovf_q;
    logic          wovf_d;

    assign wq_rptr = sync_q[SYNC_STAGES-1];

    // Read-pointer synchronizer: raw Gray input lands directly in the first flop
    always_ff @(posedge wclk) begin
        if (wrst) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= bus.rptr_gray;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // Gray-to-binary of the synchronized read pointer
    always_comb begin
        rbin = '0;
        for (int i = 0; i < int'(PW); i++) begin
            rbin[i] = ^(wq_rptr >> i);
        end
    end

    // Next pointer, flags and overflow; push and pointer arrival share one computation
    always_comb begin
        push     = bus.winc & ~wfull_q;
        wbin_d   = wbin_q + PW'(push);
        wgray_d  = wbin_d ^ (wbin_d >> 1);
        // Full when the pointers differ only in the two MSBs of their Gray codes
        full_cmp = {~wq_rptr[PW-1:PW-2], wq_rptr[PW-3:0]};
        wfull_d  = (wgray_d == full_cmp);
        // Stale read pointer can only make this larger than the true fill
        fill_d   = wbin_d - rbin;
        wafull_d = (fill_d >= PW'(AFULL_THRESH));
        wovf_d   = wovf_q;
        if (bus.winc & wfull_q) begin
            wovf_d = 1'b1;
        end else if (bus.woverflow_clr) begin
            wovf_d = 1'b0;
        end
    end

    // Pointer and flag registers
    always_ff @(posedge wclk) begin
        if (wrst) begin
            wbin_q   <= '0;
            wptr_q   <= '0;
            wfull_q  <= 1'b0;
            wafull_q <= 1'b0;
            wlevel_q <= '0;
            wovf_q   <= 1'b0;
        end else begin
            wbin_q   <= wbin_d;
            wptr_q   <= wgray_d;
            wfull_q  <= wfull_d;
            wafull_q <= wafull_d;
            wlevel_q <= fill_d;
            wovf_q   <= wovf_d;
        end
    end

    assign bus.waddr        = wbin_q[ADDRSIZE-1:0];
    assign bus.wptr         = wptr_q;
    assign bus.wfull        = wfull_q;
    assign bus.walmost_full = wafull_q;
    assign bus.wlevel       = wlevel_q;
    assign bus.woverflow    = wovf_q;

endmodule

// File: doc/fifo_wr_ctrl.md
Name: fifo_wr_ctrl

Overview:
Write-domain pointer and flag controller for the async FIFO. It sits directly upstream of the FIFO memory and drives its write address and full input. It also supplies the Gray-coded write pointer to the read domain. It synchronizes the read-domain Gray pointer into wclk and produces full, almost-full, fill level and a sticky overflow flag.

Parameters:
ADDRSIZE, 8, memory address width; FIFO depth = 2**ADDRSIZE
SYNC_STAGES, 2, flops in the read-pointer synchronizer chain (legal values >= 2)
AFULL_THRESH, 2**ADDRSIZE-4, almost-full level threshold (1..2**ADDRSIZE)

Ports:
wclk  input  1  write clock; the only clock
wrst  input  1  synchronous active-high reset
winc  input  1  write request; the word on the memory data input is committed this cycle
rptr_gray  input  ADDRSIZE+1  read pointer, Gray coded, from the read domain (asynchronous)
woverflow_clr  input  1  clears woverflow
waddr  output  ADDRSIZE  write address to the FIFO memory
wptr  output  ADDRSIZE+1  write pointer, Gray coded, to the read-domain synchronizer
wfull  output  1  FIFO full; wired to the memory full input
walmost_full  output  1  level >= AFULL_THRESH
wlevel  output  ADDRSIZE+1  conservative fill count, 0..2**ADDRSIZE
woverflow  output  1  sticky: a write was attempted while full

Behaviour:
- One clock (wclk); reset is synchronous and active-high (wrst).
- Reset (wrst=1 at a wclk edge): wbin, wptr, all synchronizer flops, wfull, walmost_full, wlevel and woverflow go to 0. waddr therefore reads 0. Reset overrides all other inputs, including mid-operation while full.
- Internal binary pointer wbin has ADDRSIZE+1 bits. Accepted push: push = winc & ~wfull. wbin_next = wbin + push, wrapping modulo 2**(ADDRSIZE+1).
- waddr = wbin[ADDRSIZE-1:0] from the register. It changes only on the edge following an accepted push.
- wptr is registered: wptr <= wbin_next ^ (wbin_next >> 1). Exactly one bit changes per push.
- Synchronizer: rptr_gray is shifted through SYNC_STAGES flops; the last stage is wq_rptr. No logic is allowed before the first flop.
- wfull (registered) <= (gray(wbin_next) == {~wq_rptr[ADDRSIZE:ADDRSIZE-1], wq_rptr[ADDRSIZE-2:0]}). It asserts on the same edge as the push that fills the last slot.
- Levels: rbin = Gray-to-binary(wq_rptr). wlevel <= (wbin_next - rbin) mod 2**(ADDRSIZE+1). walmost_full <= (wbin_next - rbin) >= AFULL_THRESH.
- wlevel only over-estimates, because of synchronizer lag; it never under-reports.
- Release latency: a change on rptr_gray is reflected in wfull, walmost_full and wlevel at the (SYNC_STAGES+1)th wclk edge after it is stable.
- Write while full (winc=1, wfull=1): the pointer does not advance, waddr and wptr hold, and woverflow <= 1.
- woverflow_clr=1 clears woverflow. If a write-while-full and a clear occur in the same cycle, set wins and woverflow stays 1.
- Simultaneous push and read-pointer update: both are applied in the same computation. wfull may stay asserted until the synchronized pointer arrives; it is never released early.
- Wrap-around: crossing 2**(ADDRSIZE+1)-1 -> 0 needs no special case. The MSB/second-MSB comparison distinguishes full from empty.

Test Plan:
All scenarios use ADDRSIZE=2, SYNC_STAGES=2, AFULL_THRESH=3.
1. Hold wrst=1 for 2 edges with random winc/rptr_gray -> waddr, wptr, wfull, walmost_full, wlevel and woverflow are all 0 after the first edge.
2. rptr_gray=0, winc=1 for 4 cycles -> waddr 1,2,3,0; wptr 001,011,010,110; wlevel 1,2,3,4; walmost_full rises after push 3; wfull rises after push 4.
3. Full, winc=1 for 2 more cycles -> waddr stays 0, wptr stays 110, woverflow=1. Then woverflow_clr=1 with winc=0 -> 0. Then winc=1 plus woverflow_clr=1 while full -> woverflow=1.
4. Full, rptr_gray 000->001 held -> wfull falls exactly 3 edges later, wlevel=3, walmost_full stays 1. Then one push -> wfull=1 again on that edge.
5. Reader tracking 1 slot behind, 10 pushes -> wbin wraps 111->000 (wptr 100->000), wfull never asserts, wlevel stays <= 3.
6. wrst=1 while full with woverflow=1 -> all outputs 0 on the next edge. Then rptr_gray=0 with 4 pushes reproduces scenario 2 exactly.
